// File: rtl/my_cpu_pkg.sv
// Shared definitions for the my_cpu RV32I pipeline.
// Covers opcode/funct encodings, the ALU operation set and the pipeline-register layouts with their NOP values.
package my_cpu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        alu_op_e           alu_op;
        logic              use_imm;
        logic              we;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
    } id_ex_t;

    // Layout shared by EX/MEM and MEM/WB, since MEM only passes data through.
    typedef struct packed {
        logic              we;
        logic [4:0]        rd;
        logic [XLEN-1:0]   data;
    } wb_t;

    localparam logic [XLEN-1:0] INST_NOP = '0;

    localparam id_ex_t ID_EX_NOP = '{
        alu_op: ALU_ADD, use_imm: 1'b0, we: 1'b0,
        rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
        rs1_val: '0, rs2_val: '0, imm: '0
    };

    localparam wb_t WB_NOP = '{we: 1'b0, rd: 5'd0, data: '0};

    function automatic logic [XLEN-1:0] sext_i(input logic [11:0] imm12);
        return {{(XLEN-12){imm12[11]}}, imm12};
    endfunction

endpackage

// File: rtl/my_cpu_regfile.sv
// 32x32 register file with two combinational read ports and one write port.
// Reads bypass a same-cycle write, and x0 always reads as zero.
module my_cpu_regfile
    import my_cpu_pkg::*;
(
    input  logic            clk,
    input  logic            srst,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [4:0]      raddr [2];
    logic [XLEN-1:0] rdata [2];

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;
    assign rdata_a  = rdata[0];
    assign rdata_b  = rdata[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = (raddr[gi] == 5'd0)               ? '0    :
                               (we && (waddr == raddr[gi]))      ? wdata :
                                                                   regs_reg[raddr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_reg[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/my_cpu.sv
// Five-stage RV32I integer pipeline (IF, ID, EX, MEM, WB) fed directly from the inst port.
// ALU hazards are resolved by forwarding only, so the pipeline never stalls.
module my_cpu
    import my_cpu_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] inst,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    logic [XLEN-1:0] if_id_inst_reg;
    id_ex_t          id_ex_reg, id_ex_next;
    wb_t             ex_mem_reg, ex_mem_next;
    wb_t             mem_wb_reg;

    logic [6:0]      id_opcode, id_f7;
    logic [2:0]      id_f3;
    logic [4:0]      id_rd, id_rs1, id_rs2;
    logic [XLEN-1:0] rf_rdata_a, rf_rdata_b;
    logic            id_legal;
    alu_op_e         id_alu_op;

    assign id_opcode = if_id_inst_reg[6:0];
    assign id_rd     = if_id_inst_reg[11:7];
    assign id_f3     = if_id_inst_reg[14:12];
    assign id_rs1    = if_id_inst_reg[19:15];
    assign id_rs2    = if_id_inst_reg[24:20];
    assign id_f7     = if_id_inst_reg[31:25];

    my_cpu_regfile u_regfile (
        .clk     (cpu_clk),
        .srst    (cpu_rst),
        .raddr_a (id_rs1),
        .raddr_b (id_rs2),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (mem_wb_reg.we),
        .waddr   (mem_wb_reg.rd),
        .wdata   (mem_wb_reg.data)
    );

    always_comb begin
        id_legal   = 1'b0;
        id_alu_op  = ALU_ADD;
        id_ex_next = ID_EX_NOP;
        id_ex_next.rd      = id_rd;
        id_ex_next.rs1     = id_rs1;
        id_ex_next.rs2     = id_rs2;
        id_ex_next.rs1_val = rf_rdata_a;
        id_ex_next.rs2_val = rf_rdata_b;
        id_ex_next.imm     = sext_i(if_id_inst_reg[31:20]);
        case (id_opcode)
            // LUI is executed as x0 + (imm20 << 12); rs1 = x0 keeps forwarding out of it.
            OPC_LUI: begin
                id_legal           = 1'b1;
                id_ex_next.use_imm = 1'b1;
                id_ex_next.rs1     = 5'd0;
                id_ex_next.rs1_val = '0;
                id_ex_next.imm     = {if_id_inst_reg[31:12], 12'd0};
            end
            OPC_OP_IMM: begin
                id_legal           = 1'b1;
                id_ex_next.use_imm = 1'b1;
                case (id_f3)
                    F3_ADD:  id_alu_op = ALU_ADD;
                    F3_SLT:  id_alu_op = ALU_SLT;
                    F3_SLTU: id_alu_op = ALU_SLTU;
                    F3_XOR:  id_alu_op = ALU_XOR;
                    F3_OR:   id_alu_op = ALU_OR;
                    F3_AND:  id_alu_op = ALU_AND;
                    F3_SLL: begin
                        id_alu_op = ALU_SLL;
                        id_legal  = (id_f7 == F7_BASE);
                    end
                    default: begin
                        id_alu_op = (id_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        id_legal  = (id_f7 == F7_BASE) || (id_f7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                id_legal = (id_f7 == F7_BASE);
                case (id_f3)
                    F3_ADD: begin
                        id_alu_op = (id_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        id_legal  = (id_f7 == F7_BASE) || (id_f7 == F7_ALT);
                    end
                    F3_SR: begin
                        id_alu_op = (id_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        id_legal  = (id_f7 == F7_BASE) || (id_f7 == F7_ALT);
                    end
                    F3_SLL:  id_alu_op = ALU_SLL;
                    F3_SLT:  id_alu_op = ALU_SLT;
                    F3_SLTU: id_alu_op = ALU_SLTU;
                    F3_XOR:  id_alu_op = ALU_XOR;
                    F3_OR:   id_alu_op = ALU_OR;
                    default: id_alu_op = ALU_AND;
                endcase
            end
            default: ;
        endcase
        id_ex_next.alu_op = id_alu_op;
        id_ex_next.we     = id_legal && (id_rd != 5'd0);
    end

    // Newest in-flight producer wins: EX/MEM first, then MEM/WB, else the ID-stage read.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] val,
                                            input wb_t near, input wb_t far);
        if (rs == 5'd0)                   return val;
        else if (near.we && near.rd == rs) return near.data;
        else if (far.we && far.rd == rs)   return far.data;
        else                               return val;
    endfunction

    logic [XLEN-1:0] ex_a, ex_b_reg, ex_b, ex_result;
    logic [4:0]      ex_shamt;

    assign ex_a     = fwd(id_ex_reg.rs1, id_ex_reg.rs1_val, ex_mem_reg, mem_wb_reg);
    assign ex_b_reg = fwd(id_ex_reg.rs2, id_ex_reg.rs2_val, ex_mem_reg, mem_wb_reg);
    assign ex_b     = id_ex_reg.use_imm ? id_ex_reg.imm : ex_b_reg;
    assign ex_shamt = ex_b[4:0];

    always_comb begin
        case (id_ex_reg.alu_op)
            ALU_SUB:  ex_result = ex_a - ex_b;
            ALU_SLL:  ex_result = ex_a << ex_shamt;
            ALU_SLT:  ex_result = {31'd0, $signed(ex_a) < $signed(ex_b)};
            ALU_SLTU: ex_result = {31'd0, ex_a < ex_b};
            ALU_XOR:  ex_result = ex_a ^ ex_b;
            ALU_SRL:  ex_result = ex_a >> ex_shamt;
            ALU_SRA:  ex_result = $unsigned($signed(ex_a) >>> ex_shamt);
            ALU_OR:   ex_result = ex_a | ex_b;
            ALU_AND:  ex_result = ex_a & ex_b;
            default:  ex_result = ex_a + ex_b;
        endcase
    end

    assign ex_mem_next = '{we: id_ex_reg.we, rd: id_ex_reg.rd, data: ex_result};

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            if_id_inst_reg <= INST_NOP;
            id_ex_reg      <= ID_EX_NOP;
            ex_mem_reg     <= WB_NOP;
            mem_wb_reg     <= WB_NOP;
        end else begin
            if_id_inst_reg <= inst;
            id_ex_reg      <= id_ex_next;
            ex_mem_reg     <= ex_mem_next;
            mem_wb_reg     <= ex_mem_reg;
        end
    end

    assign wb_en   = mem_wb_reg.we;
    assign wb_rd   = mem_wb_reg.rd;
    assign wb_data = mem_wb_reg.data;

endmodule

// File: tb/tb_my_cpu.sv
// Self-checking bench for my_cpu: each issued writing instruction queues its expected
// retirement cycle, rd and value; a monitor compares every cycle against the queue head.
module tb_my_cpu;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cycle_cnt  = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    my_cpu dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .inst    (inst),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cycle_cnt);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // Sampled at the following edge; visible on the WB port three edges after that.
    task automatic issue(input logic [31:0] i, input logic w, input logic [4:0] rd,
                         input logic [31:0] d);
        @(negedge cpu_clk);
        inst = i;
        if (w) exp_q.push_back('{cyc: cycle_cnt + 4, rd: rd, data: d});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) issue(32'h0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge cpu_clk);
            #1;
            if (exp_q.size() > 0 && exp_q[0].cyc == cycle_cnt) begin
                e = exp_q.pop_front();
                $display("[%0d] retire x%0d <= %08h (want x%0d <= %08h)",
                         cycle_cnt, wb_rd, wb_data, e.rd, e.data);
                check_eq("wb_en", {31'd0, wb_en}, 32'd1);
                check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check_eq("wb_data", wb_data, e.data);
            end else begin
                check_eq("idle_wb_en", {31'd0, wb_en}, 32'd0);
            end
        end
    end

    initial begin : stim
        cpu_rst = 1'b1;
        inst    = 32'h0;
        repeat (2) @(negedge cpu_clk);
        check_eq("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check_eq("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        cpu_rst = 1'b0;

        // Basic retirement; last one reads x1 through the regfile bypass.
        issue(32'h00100093, 1'b1, 5'd1, 32'd1);
        issue(32'h00200113, 1'b1, 5'd2, 32'd2);
        issue(32'h00300193, 1'b1, 5'd3, 32'd3);
        issue(32'h00408213, 1'b1, 5'd4, 32'd5);

        // Distance 1 and distance 2 forwarding.
        issue(32'h00700093, 1'b1, 5'd1, 32'd7);
        issue(32'h00108113, 1'b1, 5'd2, 32'd8);
        issue(32'h00700093, 1'b1, 5'd1, 32'd7);
        issue(32'h00000000, 1'b0, 5'd0, 32'd0);
        issue(32'h00108113, 1'b1, 5'd2, 32'd8);

        // Write to x0 is dropped and never forwarded.
        issue(32'h00500013, 1'b0, 5'd0, 32'd0);
        issue(32'h00100093, 1'b1, 5'd1, 32'd1);

        // Shifts and unsigned compare on a negative value.
        issue(32'hFF800093, 1'b1, 5'd1, 32'hFFFFFFF8);
        issue(32'h4010D113, 1'b1, 5'd2, 32'hFFFFFFFC);
        issue(32'h01C0D193, 1'b1, 5'd3, 32'h0000000F);
        issue(32'h00103233, 1'b1, 5'd4, 32'd1);

        // Remaining ALU operations.
        issue(enc_r(7'h20, 5'd4, 5'd3, 3'd0, 5'd5), 1'b1, 5'd5, 32'h0000000E);
        issue(enc_r(7'h00, 5'd3, 5'd1, 3'd2, 5'd6), 1'b1, 5'd6, 32'd1);
        issue(enc_r(7'h00, 5'd3, 5'd1, 3'd3, 5'd7), 1'b1, 5'd7, 32'd0);
        issue(enc_lui(20'hABCDE, 5'd8), 1'b1, 5'd8, 32'hABCDE000);
        issue(enc_i(12'hFFF, 5'd8, 3'd4, 5'd9), 1'b1, 5'd9, 32'h54321FFF);
        issue(enc_r(7'h00, 5'd4, 5'd3, 3'd1, 5'd10), 1'b1, 5'd10, 32'h0000001E);
        issue(enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd11), 1'b1, 5'd11, 32'hFFFFFFFF);
        issue(enc_i(12'hFF9, 5'd1, 3'd2, 5'd12), 1'b1, 5'd12, 32'd1);
        issue(enc_i(12'h100, 5'd3, 3'd6, 5'd13), 1'b1, 5'd13, 32'h0000010F);
        issue(enc_r(7'h00, 5'd12, 5'd13, 3'd0, 5'd14), 1'b1, 5'd14, 32'h00000110);

        // Unsupported encodings: a store and an slli with a bad funct7.
        issue(32'h00112023, 1'b0, 5'd0, 32'd0);
        issue(enc_i(12'h401, 5'd1, 3'd1, 5'd15), 1'b0, 5'd0, 32'd0);
        drain(5);

        // Reset with three instructions in flight: none of them may retire.
        issue(enc_i(12'd9, 5'd0, 3'd0, 5'd5), 1'b0, 5'd0, 32'd0);
        issue(enc_i(12'd10, 5'd0, 3'd0, 5'd6), 1'b0, 5'd0, 32'd0);
        issue(enc_i(12'd11, 5'd0, 3'd0, 5'd7), 1'b0, 5'd0, 32'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        inst    = enc_i(12'd33, 5'd0, 3'd0, 5'd16);
        @(negedge cpu_clk);
        check_eq("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check_eq("midrst_wb_data", wb_data, 32'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        inst    = 32'h0;

        // Every register must read back zero: add xk, xk, x0.
        for (int k = 1; k < 32; k++) begin
            issue(enc_r(7'h00, 5'd0, k[4:0], 3'd0, k[4:0]), 1'b1, k[4:0], 32'd0);
        end
        drain(6);
        check_eq("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
